// File: rtl/id_stage_reg_if.sv
// ID/EX pipeline bus: decoded control, operands and forwarding fields entering
// the stage (_IN) and their registered copies leaving it (_OUT).
interface id_stage_reg_if;
    logic        WB_EN_IN;
    logic        MEM_R_EN_IN;
    logic        MEM_W_EN_IN;
    logic        B_IN;
    logic        S_IN;
    logic [3:0]  EXE_CMD_IN;
    logic [31:0] PC_IN;
    logic [31:0] Val_Rn_IN;
    logic [31:0] Val_Rm_IN;
    logic        imm_IN;
    logic [11:0] Shift_operand_IN;
    logic [23:0] Signed_imm_24_IN;
    logic [3:0]  Dest_IN;
    logic [3:0]  src1_IN;
    logic [3:0]  src2_IN;
    logic [3:0]  SR_IN;

    logic        WB_EN_OUT;
    logic        MEM_R_EN_OUT;
    logic        MEM_W_EN_OUT;
    logic        B_OUT;
    logic        S_OUT;
    logic [3:0]  EXE_CMD_OUT;
    logic [31:0] PC_OUT;
    logic [31:0] Val_Rn_OUT;
    logic [31:0] Val_Rm_OUT;
    logic        imm_OUT;
    logic [11:0] Shift_operand_OUT;
    logic [23:0] Signed_imm_24_OUT;
    logic [3:0]  Dest_OUT;
    logic [3:0]  src1_OUT;
    logic [3:0]  src2_OUT;
    logic [3:0]  SR_OUT;
    logic        VALID_OUT;
    logic [15:0] BUBBLE_CNT;

    modport master (
        output WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
               PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
               Signed_imm_24_IN, Dest_IN, src1_IN, src2_IN, SR_IN,
        input  WB_EN_OUT, MEM_R_EN_OUT, MEM_W_EN_OUT, B_OUT, S_OUT, EXE_CMD_OUT,
               PC_OUT, Val_Rn_OUT, Val_Rm_OUT, imm_OUT, Shift_operand_OUT,
               Signed_imm_24_OUT, Dest_OUT, src1_OUT, src2_OUT, SR_OUT,
               VALID_OUT, BUBBLE_CNT
    );

    modport slave (
        input  WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN, B_IN, S_IN, EXE_CMD_IN,
               PC_IN, Val_Rn_IN, Val_Rm_IN, imm_IN, Shift_operand_IN,
               Signed_imm_24_IN, Dest_IN, src1_IN, src2_IN, SR_IN,
        output WB_EN_OUT, MEM_R_EN_OUT, MEM_W_EN_OUT, B_OUT, S_OUT, EXE_CMD_OUT,
               PC_OUT, Val_Rn_OUT, Val_Rm_OUT, imm_OUT, Shift_operand_OUT,
               Signed_imm_24_OUT, Dest_OUT, src1_OUT, src2_OUT, SR_OUT,
               VALID_OUT, BUBBLE_CNT
    );
endinterface

// File: rtl/id_stage_reg.sv
// ID/EX pipeline register: one-cycle bit-exact payload register with freeze,
// bubble insertion on flush/hazard, and a saturating bubble counter.
module id_stage_reg (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hazard,
    input  logic          freeze,
    id_stage_reg_if.slave bus
);

    typedef enum logic [1:0] {
        ACT_RESET  = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_LOAD   = 2'd3
    } action_t;

    action_t     w_action;

    logic        r_wb_en;
    logic        r_mem_r_en;
    logic        r_mem_w_en;
    logic        r_b;
    logic        r_s;
    logic [3:0]  r_exe_cmd;
    logic [31:0] r_pc;
    logic [31:0] r_val_rn;
    logic [31:0] r_val_rm;
    logic        r_imm;
    logic [11:0] r_shift_operand;
    logic [23:0] r_signed_imm_24;
    logic [3:0]  r_dest;
    logic [3:0]  r_src1;
    logic [3:0]  r_src2;
    logic [3:0]  r_sr;
    logic        r_valid;
    logic [15:0] r_bubble_cnt;

    // Priority: reset, freeze, bubble, load.
    always_comb begin
        w_action = ACT_LOAD;
        if (!rst)
            w_action = ACT_RESET;
        else if (freeze)
            w_action = ACT_HOLD;
        else if (flush || hazard)
            w_action = ACT_BUBBLE;
    end

    always_ff @(posedge clk) begin
        case (w_action)
            ACT_RESET, ACT_BUBBLE: begin
                r_wb_en         <= 1'b0;
                r_mem_r_en      <= 1'b0;
                r_mem_w_en      <= 1'b0;
                r_b             <= 1'b0;
                r_s             <= 1'b0;
                r_exe_cmd       <= '0;
                r_pc            <= '0;
                r_val_rn        <= '0;
                r_val_rm        <= '0;
                r_imm           <= 1'b0;
                r_shift_operand <= '0;
                r_signed_imm_24 <= '0;
                r_dest          <= '0;
                r_src1          <= '0;
                r_src2          <= '0;
                r_sr            <= '0;
                r_valid         <= 1'b0;
                if (w_action == ACT_RESET)
                    r_bubble_cnt <= '0;
                else if (r_bubble_cnt != '1)
                    r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
            ACT_LOAD: begin
                r_wb_en         <= bus.WB_EN_IN;
                r_mem_r_en      <= bus.MEM_R_EN_IN;
                r_mem_w_en      <= bus.MEM_W_EN_IN;
                r_b             <= bus.B_IN;
                r_s             <= bus.S_IN;
                r_exe_cmd       <= bus.EXE_CMD_IN;
                r_pc            <= bus.PC_IN;
                r_val_rn        <= bus.Val_Rn_IN;
                r_val_rm        <= bus.Val_Rm_IN;
                r_imm           <= bus.imm_IN;
                r_shift_operand <= bus.Shift_operand_IN;
                r_signed_imm_24 <= bus.Signed_imm_24_IN;
                r_dest          <= bus.Dest_IN;
                r_src1          <= bus.src1_IN;
                r_src2          <= bus.src2_IN;
                r_sr            <= bus.SR_IN;
                r_valid         <= 1'b1;
            end
            default: ; // ACT_HOLD: every register keeps its value
        endcase
    end

    assign bus.WB_EN_OUT         = r_wb_en;
    assign bus.MEM_R_EN_OUT      = r_mem_r_en;
    assign bus.MEM_W_EN_OUT      = r_mem_w_en;
    assign bus.B_OUT             = r_b;
    assign bus.S_OUT             = r_s;
    assign bus.EXE_CMD_OUT       = r_exe_cmd;
    assign bus.PC_OUT            = r_pc;
    assign bus.Val_Rn_OUT        = r_val_rn;
    assign bus.Val_Rm_OUT        = r_val_rm;
    assign bus.imm_OUT           = r_imm;
    assign bus.Shift_operand_OUT = r_shift_operand;
    assign bus.Signed_imm_24_OUT = r_signed_imm_24;
    assign bus.Dest_OUT          = r_dest;
    assign bus.src1_OUT          = r_src1;
    assign bus.src2_OUT          = r_src2;
    assign bus.SR_OUT            = r_sr;
    assign bus.VALID_OUT         = r_valid;
    assign bus.BUBBLE_CNT        = r_bubble_cnt;

endmodule

// File: tb/tb_id_stage_reg.sv
// Scoreboard bench for id_stage_reg: a reference model pushes the expected
// stage contents each edge; each test pops and compares after the edge.
module tb_id_stage_reg;

    typedef struct packed {
        logic        wb_en;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        b;
        logic        s;
        logic [3:0]  exe_cmd;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic        imm;
        logic [11:0] shift_operand;
        logic [23:0] signed_imm_24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  sr;
    } pay_t;

    typedef struct packed {
        pay_t        pay;
        logic        valid;
        logic [15:0] cnt;
    } state_t;

    logic clk;
    logic rst;
    logic flush;
    logic hazard;
    logic freeze;
    pay_t in_vec;

    id_stage_reg_if bus ();

    id_stage_reg dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .hazard (hazard),
        .freeze (freeze),
        .bus    (bus.slave)
    );

    assign {bus.WB_EN_IN, bus.MEM_R_EN_IN, bus.MEM_W_EN_IN, bus.B_IN, bus.S_IN,
            bus.EXE_CMD_IN, bus.PC_IN, bus.Val_Rn_IN, bus.Val_Rm_IN, bus.imm_IN,
            bus.Shift_operand_IN, bus.Signed_imm_24_IN, bus.Dest_IN,
            bus.src1_IN, bus.src2_IN, bus.SR_IN} = in_vec;

    state_t obs;
    assign obs = {bus.WB_EN_OUT, bus.MEM_R_EN_OUT, bus.MEM_W_EN_OUT, bus.B_OUT,
                  bus.S_OUT, bus.EXE_CMD_OUT, bus.PC_OUT, bus.Val_Rn_OUT,
                  bus.Val_Rm_OUT, bus.imm_OUT, bus.Shift_operand_OUT,
                  bus.Signed_imm_24_OUT, bus.Dest_OUT, bus.src1_OUT,
                  bus.src2_OUT, bus.SR_OUT, bus.VALID_OUT, bus.BUBBLE_CNT};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    state_t model;
    state_t exp_q[$];
    state_t exp_s;

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic pay_t rand_pay();
        pay_t p;
        p = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return p;
    endfunction

    // Drive one edge's stimulus, advance the model and queue the expectation.
    task automatic apply(input logic r, input logic fl, input logic hz,
                         input logic fz, input pay_t d);
        rst = r; flush = fl; hazard = hz; freeze = fz; in_vec = d;
        if (!r) begin
            model = '0;
        end else if (fz) begin
            model = model;
        end else if (fl || hz) begin
            model.pay   = '0;
            model.valid = 1'b0;
            if (model.cnt != 16'hFFFF) model.cnt = model.cnt + 16'd1;
        end else begin
            model.pay   = d;
            model.valid = 1'b1;
        end
        exp_q.push_back(model);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) begin
            apply(1'b0, 1'b1, 1'b1, 1'b1, '1);
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                failures++;
                $display("FAIL reset obs=%h exp=%h", obs, exp_s);
            end
        end
        checks++;
        if (bus.VALID_OUT !== 1'b0 || bus.BUBBLE_CNT !== 16'd0) begin
            failures++;
            $display("FAIL reset_flags valid=%b cnt=%h exp 0/0", bus.VALID_OUT, bus.BUBBLE_CNT);
        end
    endtask

    task automatic test_load();
        pay_t p;
        p = '0;
        p.exe_cmd = 4'b0010;
        p.wb_en   = 1'b1;
        p.val_rn  = 32'h0000_0005;
        p.dest    = 4'd3;
        apply(1'b1, 1'b0, 1'b0, 1'b0, p);
        exp_s = exp_q.pop_front();
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL load obs=%h exp=%h", obs, exp_s);
        end
        checks++;
        if (bus.EXE_CMD_OUT !== 4'b0010 || bus.WB_EN_OUT !== 1'b1 ||
            bus.Val_Rn_OUT !== 32'h5 || bus.Dest_OUT !== 4'd3 || bus.VALID_OUT !== 1'b1) begin
            failures++;
            $display("FAIL load_fields exe=%h wb=%b rn=%h dest=%h valid=%b exp 2/1/5/3/1",
                     bus.EXE_CMD_OUT, bus.WB_EN_OUT, bus.Val_Rn_OUT, bus.Dest_OUT, bus.VALID_OUT);
        end
    endtask

    // Assumes the stage holds the load from test_load.
    task automatic test_freeze();
        state_t held;
        held = obs;
        repeat (3) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, '1);
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                failures++;
                $display("FAIL freeze obs=%h exp=%h", obs, exp_s);
            end
        end
        checks++;
        if (bus.EXE_CMD_OUT !== 4'b0010 || bus.Val_Rn_OUT !== 32'h5 ||
            bus.BUBBLE_CNT !== 16'd0 || bus.VALID_OUT !== 1'b1) begin
            failures++;
            $display("FAIL freeze_held exe=%h rn=%h cnt=%h valid=%b exp 2/5/0/1",
                     bus.EXE_CMD_OUT, bus.Val_Rn_OUT, bus.BUBBLE_CNT, bus.VALID_OUT);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, rand_pay());
        exp_s = exp_q.pop_front();
        checks++;
        if (obs !== exp_s) begin
            failures++;
            $display("FAIL freeze_resume obs=%h exp=%h", obs, exp_s);
        end
    endtask

    task automatic test_bubble();
        pay_t        p;
        logic [15:0] cnt0;
        for (int unsigned k = 0; k < 3; k++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, rand_pay());
            void'(exp_q.pop_front());
            cnt0 = bus.BUBBLE_CNT;
            p = '1;
            apply(1'b1, (k != 1), (k != 0), 1'b0, p);
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                failures++;
                $display("FAIL bubble%0d obs=%h exp=%h", k, obs, exp_s);
            end
            checks++;
            if ({bus.WB_EN_OUT, bus.MEM_R_EN_OUT, bus.MEM_W_EN_OUT, bus.B_OUT,
                 bus.S_OUT, bus.VALID_OUT} !== 6'b0 || bus.BUBBLE_CNT !== cnt0 + 16'd1) begin
                failures++;
                $display("FAIL bubble%0d_ctl ctl=%b cnt=%h exp 000000/%h", k,
                         {bus.WB_EN_OUT, bus.MEM_R_EN_OUT, bus.MEM_W_EN_OUT,
                          bus.B_OUT, bus.S_OUT, bus.VALID_OUT},
                         bus.BUBBLE_CNT, cnt0 + 16'd1);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int unsigned i = 0; i < 40; i++) begin
            apply(1'b1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), rand_pay());
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s) begin
                failures++;
                $display("FAIL b2b%0d obs=%h exp=%h", i, obs, exp_s);
            end
        end
    endtask

    task automatic test_reset_priority();
        apply(1'b1, 1'b0, 1'b0, 1'b0, rand_pay());
        void'(exp_q.pop_front());
        apply(1'b0, 1'b0, 1'b0, 1'b1, rand_pay());
        exp_s = exp_q.pop_front();
        checks++;
        if (obs !== exp_s || obs !== '0) begin
            failures++;
            $display("FAIL reset_in_freeze obs=%h exp=%h", obs, exp_s);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, rand_pay());
        void'(exp_q.pop_front());
        apply(1'b0, 1'b1, 1'b1, 1'b0, rand_pay());
        exp_s = exp_q.pop_front();
        checks++;
        if (obs !== exp_s || obs !== '0) begin
            failures++;
            $display("FAIL reset_in_bubble obs=%h exp=%h", obs, exp_s);
        end
        apply(1'b1, 1'b0, 1'b0, 1'b0, rand_pay());
        exp_s = exp_q.pop_front();
        checks++;
        if (obs !== exp_s || bus.VALID_OUT !== 1'b1 || bus.BUBBLE_CNT !== 16'd0) begin
            failures++;
            $display("FAIL first_load obs=%h exp=%h", obs, exp_s);
        end
    endtask

    task automatic test_saturation();
        apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
        void'(exp_q.pop_front());
        for (int unsigned i = 0; i < 65534; i++) begin
            apply(1'b1, i[0], ~i[0], 1'b0, rand_pay());
            void'(exp_q.pop_front());
        end
        checks++;
        if (bus.BUBBLE_CNT !== 16'hFFFE) begin
            failures++;
            $display("FAIL sat_preload cnt=%h exp=fffe", bus.BUBBLE_CNT);
        end
        for (int unsigned i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b0, rand_pay());
            exp_s = exp_q.pop_front();
            checks++;
            if (obs !== exp_s || bus.BUBBLE_CNT !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat%0d cnt=%h exp=ffff obs=%h exp=%h", i,
                         bus.BUBBLE_CNT, obs, exp_s);
            end
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; hazard = 1'b0; freeze = 1'b0; in_vec = '0;
        model = '0;
        @(negedge clk);
        test_reset();
        test_load();
        test_freeze();
        test_bubble();
        test_back_to_back();
        test_reset_priority();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
